// File: rtl/seq_counter_param_pkg.sv
// Shared encodings and helpers for the programmable-sequence counter.
// Imported by the table register file and the top-level control.
package seq_counter_param_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  localparam logic DIR_FWD      = 1'b0;
  localparam logic DIR_REV      = 1'b1;

  // Outcome of the step decision for one clock.
  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_MOVE,
    STEP_WRAP,
    STEP_STOP
  } step_kind_e;

  // A zero or oversized length request falls back to the full table.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    return (len == 0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/seq_counter_param_table.sv
// DEPTH x WIDTH code table: identity contents after reset, one write port,
// one combinational read port addressed by the current sequence index.
module seq_table
  import seq_counter_param_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(i);
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/seq_counter_param.sv
// Programmable-sequence counter: steps an index through a writable code table
// with up/down, wrap/one-shot, index load, length control and terminal pulse.
module seq_counter_param
  import seq_counter_param_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int IDXW = $clog2(DEPTH),
  localparam int LENW = IDXW + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [IDXW-1:0]  load_idx,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             len_we,
  input  logic [LENW-1:0]  len_data,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  idx,
  output logic             tc,
  output logic             done
);

  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);
  localparam logic [LENW-1:0] LEN_MAX = LENW'(DEPTH);

  logic [LENW-1:0] len_q;
  logic [LENW-1:0] len_eff;
  logic [IDXW-1:0] last_idx;
  logic            at_end;
  step_kind_e      kind;
  logic [IDXW-1:0] step_idx;
  logic [IDXW-1:0] idx_nxt;
  logic            tc_nxt;
  logic            done_nxt;

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clock   (clock),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (q)
  );

  always_comb begin
    len_eff  = len_q;
    last_idx = IDXW'(len_q - LEN_ONE);
    at_end   = 1'b0;
    kind     = STEP_HOLD;
    step_idx = idx;
    idx_nxt  = idx;
    tc_nxt   = 1'b0;
    done_nxt = done;

    // A length written this cycle already governs the range check and load.
    if (len_we) begin
      len_eff = LENW'(clamp_len(32'(len_data), DEPTH));
    end

    at_end = (dir == DIR_FWD) ? (idx == last_idx) : (idx == '0);

    if (en && !done) begin
      if (!at_end) begin
        kind = STEP_MOVE;
      end else if (mode == MODE_WRAP) begin
        kind = STEP_WRAP;
      end else begin
        kind = STEP_STOP;
      end
    end

    case (kind)
      STEP_MOVE: step_idx = (dir == DIR_FWD) ? idx + IDX_ONE : idx - IDX_ONE;
      STEP_WRAP: step_idx = (dir == DIR_FWD) ? '0 : last_idx;
      default:   step_idx = idx;
    endcase

    idx_nxt  = step_idx;
    tc_nxt   = (kind == STEP_WRAP) || (kind == STEP_STOP);
    done_nxt = done || (kind == STEP_STOP);

    // Keep the index inside the active length when the length shrinks.
    if ({1'b0, idx} >= len_eff || {1'b0, step_idx} >= len_eff) begin
      idx_nxt = '0;
    end

    if (load) begin
      idx_nxt  = ({1'b0, load_idx} < len_eff) ? load_idx : '0;
      tc_nxt   = 1'b0;
      done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      idx   <= '0;
      len_q <= LEN_MAX;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      idx   <= idx_nxt;
      len_q <= len_eff;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_counter_param.sv
// Bench for seq_counter_param: directed scenarios followed by random traffic,
// all checked against an integer-level model of the sequencer.
module tb_seq_counter_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int IDXW  = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic             en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
  logic [IDXW-1:0]  load_idx = '0;
  logic             wr_en = 1'b0;
  logic [IDXW-1:0]  wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             len_we = 1'b0;
  logic [IDXW:0]    len_data = '0;
  logic [WIDTH-1:0] q;
  logic [IDXW-1:0]  idx;
  logic             tc;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  int m_tbl [DEPTH];
  int m_idx, m_len, m_tc, m_done;

  seq_counter_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .clear    (clear),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_idx (load_idx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .len_we   (len_we),
    .len_data (len_data),
    .q        (q),
    .idx      (idx),
    .tc       (tc),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % (1 << WIDTH);
    m_idx = 0; m_len = DEPTH; m_tc = 0; m_done = 0;
  endtask

  task automatic compare_all();
    check_val("q",    32'(q),    32'(m_tbl[m_idx]));
    check_val("idx",  32'(idx),  32'(m_idx));
    check_val("tc",   32'(tc),   32'(m_tc));
    check_val("done", 32'(done), 32'(m_done));
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // then let the DUT take the same edge and compare.
  task automatic tick();
    int nl, old_idx, terminal;
    nl = len_we ? ((int'(len_data) == 0 || int'(len_data) > DEPTH) ? DEPTH : int'(len_data))
                : m_len;
    old_idx = m_idx;
    if (load) begin
      m_idx  = (int'(load_idx) < nl) ? int'(load_idx) : 0;
      m_tc   = 0;
      m_done = 0;
    end else begin
      m_tc = 0;
      if (en && !m_done) begin
        terminal = (dir == 1'b0) ? (m_idx == m_len - 1) : (m_idx == 0);
        if (!terminal) begin
          m_idx = (dir == 1'b0) ? m_idx + 1 : m_idx - 1;
        end else begin
          m_tc = 1;
          if (mode == 1'b0) m_idx = (dir == 1'b0) ? 0 : m_len - 1;
          else              m_done = 1;
        end
      end
      if (old_idx >= nl || m_idx >= nl) m_idx = 0;
    end
    if (wr_en) m_tbl[wr_addr] = int'(wr_data);
    m_len = nl;
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle();
    en = 1'b0; load = 1'b0; wr_en = 1'b0; len_we = 1'b0;
  endtask

  initial begin
    int q_exp [5];
    int tc_exp [5];
    q_exp  = '{3, 14, 6, 9, 3};
    tc_exp = '{0, 0, 0, 1, 0};

    model_reset();
    #3;
    compare_all();
    check_val("reset_q", 32'(q), 32'd0);
    @(negedge clock);
    clear = 1'b1;

    // Reset mid-count
    en = 1'b1;
    repeat (5) tick();
    check_val("count_idx5", 32'(idx), 32'd5);
    #2 clear = 1'b0;
    #1;
    model_reset();
    check_val("arst_q",    32'(q),    32'd0);
    check_val("arst_idx",  32'(idx),  32'd0);
    check_val("arst_tc",   32'(tc),   32'd0);
    check_val("arst_done", 32'(done), 32'd0);
    clear = 1'b1;
    idle();

    // Program {9,3,14,6}, length 4, forward wrap
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = IDXW'(i);
      wr_data = (i == 0) ? 4'd9 : (i == 1) ? 4'd3 : (i == 2) ? 4'd14 : 4'd6;
      len_we = 1'b1; len_data = 5'd4;
      tick();
    end
    idle();
    mode = 1'b0; dir = 1'b0;
    check_val("seq_q_start", 32'(q), 32'd9);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("seq_q",  32'(q),  32'(q_exp[i]));
      check_val("seq_tc", 32'(tc), 32'(tc_exp[i]));
    end
    idle();

    // One-shot reverse from index 2
    mode = 1'b1; dir = 1'b1; load = 1'b1; load_idx = 4'd2;
    tick();
    load = 1'b0;
    check_val("os_q_load", 32'(q), 32'd14);
    en = 1'b1;
    tick(); check_val("os_q1", 32'(q), 32'd3);
    tick(); check_val("os_q2", 32'(q), 32'd9);
    tick(); check_val("os_done", 32'(done), 32'd1); check_val("os_tc", 32'(tc), 32'd1);
    tick(); check_val("os_hold_q", 32'(q), 32'd9); check_val("os_tc_off", 32'(tc), 32'd0);
    dir = 1'b0; mode = 1'b0;
    tick(); check_val("os_dir_blocked", 32'(idx), 32'd0); check_val("os_mode_done", 32'(done), 32'd1);
    en = 1'b0; load = 1'b1; load_idx = 4'd0;
    tick(); check_val("os_clear_done", 32'(done), 32'd0);
    idle();

    // Length shrink and full-length wrap
    mode = 1'b0; dir = 1'b0;
    len_we = 1'b1; len_data = 5'd0; tick(); idle();
    load = 1'b1; load_idx = 4'd7; tick(); idle();
    check_val("len_pre_idx", 32'(idx), 32'd7);
    len_we = 1'b1; len_data = 5'd4; tick(); idle();
    check_val("len_shrink_idx", 32'(idx), 32'd0);
    len_we = 1'b1; len_data = 5'd0; tick(); idle();
    load = 1'b1; load_idx = 4'd15; tick(); idle();
    en = 1'b1; tick(); idle();
    check_val("wrap16_idx", 32'(idx), 32'd0);
    check_val("wrap16_tc",  32'(tc),  32'd1);

    // Load beats step; out-of-range load goes to 0
    load = 1'b1; en = 1'b1; load_idx = 4'd3; tick(); idle();
    check_val("load_wins", 32'(idx), 32'd3);
    len_we = 1'b1; len_data = 5'd4; tick(); idle();
    load = 1'b1; load_idx = 4'd12; tick(); idle();
    check_val("load_oor", 32'(idx), 32'd0);

    // Write plus step on one edge
    len_we = 1'b1; len_data = 5'd16; tick(); idle();
    load = 1'b1; load_idx = 4'd1; tick(); idle();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hF; en = 1'b1; dir = 1'b0;
    tick(); idle();
    check_val("wr_step_idx", 32'(idx), 32'd2);
    check_val("wr_step_q",   32'(q),   32'd15);

    // Length 1 in wrap mode pulses tc every step
    len_we = 1'b1; len_data = 5'd1; tick(); idle();
    en = 1'b1;
    tick(); check_val("len1_tc", 32'(tc), 32'd1);
    tick(); check_val("len1_idx", 32'(idx), 32'd0);
    idle();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      en       = ($urandom % 4) != 0;
      dir      = 1'($urandom);
      mode     = ($urandom % 3) == 0;
      load     = ($urandom % 12) == 0;
      load_idx = IDXW'($urandom);
      wr_en    = ($urandom % 4) == 0;
      wr_addr  = IDXW'($urandom);
      wr_data  = WIDTH'($urandom);
      len_we   = ($urandom % 16) == 0;
      len_data = 5'($urandom_range(0, 18));
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
